apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//   Initiator end of the APB_BUS interface: turns a core-side req/gnt/rvalid
//   request into one APB3 transfer (SETUP then ACCESS) on the SoC peripheral
//   bus. It feeds the APB address decoder (UART, GPIO, SPI, TIMER, ...,
//   0x1A10_0000-0x1A11_7FFF). A programmable timeout stops a slave that never
//   raises pready from hanging the core.
// PARAMETERS
//   APB_ADDR_WIDTH  32   paddr width
//   APB_DATA_WIDTH  32   pwdata/prdata width
//   TIMEOUT_CYCLES  256  max ACCESS cycles without pready; 0 = no timeout
// PORTS
//   clk          in   1   clock; all logic is rising-edge
//   rst_n        in   1   reset, asynchronous, active-low
//   req_i        in   1   core request
//   addr_i       in   AW  byte address
//   we_i         in   1   1 = write, 0 = read
//   wdata_i      in   DW  write data
//   gnt_o        out  1   request accepted (combinational)
//   rvalid_o     out  1   response valid, 1-cycle pulse
//   rdata_o      out  DW  read data; 0 for writes and on error
//   err_o        out  1   pslverr or timeout; qualified by rvalid_o
//   paddr_o      out  AW  APB paddr
//   pwdata_o     out  DW  APB pwdata
//   pwrite_o     out  1   APB pwrite
//   psel_o       out  1   APB psel
//   penable_o    out  1   APB penable
//   prdata_i     in   DW  APB prdata
//   pready_i     in   1   APB pready
//   pslverr_i    in   1   APB pslverr
// BEHAVIOUR
//   Reset values: state=IDLE; psel/penable/pwrite/rvalid/err=0;
//     paddr/pwdata/rdata=0; timeout counter=0.
//   FSM states: IDLE, SETUP, ACCESS.
//   - IDLE: gnt_o = req_i. On req_i, latch addr_i, we_i, wdata_i and go to
//     SETUP. gnt_o is 0 in every other state.
//   - SETUP: psel=1, penable=0. Go to ACCESS unconditionally next cycle.
//     pready_i is ignored in this state.
//   - ACCESS: psel=1, penable=1. Counter increments each ACCESS cycle.
//     If pready_i=1: on this edge set rvalid_o=1, err_o=pslverr_i,
//       rdata_o = (!pwrite && !pslverr_i) ? prdata_i : 0; go to IDLE.
//     Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: abort.
//       Set rvalid_o=1, err_o=1, rdata_o=0; go to IDLE.
//   - Counter clears on entry to SETUP. Width is $clog2(TIMEOUT_CYCLES+1).
//   Latency with zero wait states: gnt @T0, SETUP @T1, ACCESS @T2,
//     rvalid @T3. Each wait state adds 1 cycle.
//   Throughput: IDLE accepts a new req in the same cycle as rvalid_o, so
//     back-to-back transfers take 3 cycles each.
//   paddr/pwdata/pwrite are registered and stable from SETUP through the end
//     of ACCESS. They hold their value in IDLE; no glitch when psel=0.
//     pwdata is driven for reads too (last latched value).
//   rvalid_o deasserts the cycle after its pulse. err_o/rdata_o hold until
//     the next rvalid_o.
//   Timeout is treated as an aborted transfer. psel drops with no completed
//     APB handshake, and a late pready_i in IDLE is ignored.
//   Asynchronous reset mid-transfer: psel/penable drop immediately, the FSM
//     returns to IDLE, and no rvalid_o is produced for the lost transfer.
// TESTING
//   1 Read 0x1A10_1000, pready=1 on first ACCESS, prdata=0xA5A5_0001 ->
//     psel@T1, penable@T2, rvalid@T3, rdata=0xA5A5_0001, err=0.
//   2 Write 0x1A10_3004 data 0x0000_00FF, 3 wait states -> paddr/pwdata/pwrite
//     stable for 5 cycles, rvalid@T6, rdata=0, err=0.
//   3 Read with pready=1, pslverr=1, prdata=0x1234 -> rvalid, err=1, rdata=0.
//   4 TIMEOUT_CYCLES=16, pready held 0 -> psel drops after 16 ACCESS cycles,
//     rvalid with err=1; pready=1 one cycle later is ignored.
//   5 req_i held high for 4 reads, pready=1 -> gnt every 3rd cycle (T0,T3,T6,T9),
//     4 rvalid pulses in order with correct data.
//   6 rst_n low during ACCESS -> psel/penable=0 at once, no rvalid; first req
//     after rst_n rises completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// Core req/gnt/rvalid to APB3 initiator: one SETUP+ACCESS transfer per request,
// with an optional ACCESS-phase timeout so a silent slave cannot stall the core.
module apb_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  // Keep at least one counter bit when the timeout is disabled.
  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      write_q, write_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      rvalid_q, rvalid_d;
  logic                      err_q, err_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rvalid_d = 1'b0;
    cnt_d    = cnt_q;
    gnt_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_o = req_i;
        if (req_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          write_d = we_i;
          cnt_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        cnt_d = cnt_q + CntW'(1);
        if (pready_i) begin
          rvalid_d = 1'b1;
          err_d    = pslverr_i;
          rdata_d  = (!write_q && !pslverr_i) ? prdata_i : '0;
          state_d  = StIdle;
        end else if (timeout_hit) begin
          // Abort: psel drops without a completed APB handshake.
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          rdata_d  = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign psel_o    = (state_q != StIdle);
  assign penable_o = (state_q == StAccess);
  assign paddr_o   = addr_q;
  assign pwdata_o  = wdata_q;
  assign pwrite_o  = write_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: stimulus pushes expected responses, a
// negedge monitor pops and compares them whenever rvalid_o pulses.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o, rvalid_o, err_o, pwrite_o, psel_o, penable_o;
  logic [31:0] rdata_o, paddr_o, pwdata_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;
  resp_t exp_q[$];

  always #5 clk = ~clk;

  apb_master_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .paddr_o  (paddr_o),
    .pwdata_o (pwdata_o),
    .pwrite_o (pwrite_o),
    .psel_o   (psel_o),
    .penable_o(penable_o),
    .prdata_i (prdata_i),
    .pready_i (pready_i),
    .pslverr_i(pslverr_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rvalid: got rdata %0h err %0b with nothing outstanding",
                 rdata_o, err_o);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", 64'(rdata_o), 64'(e.rdata));
        chk("resp_err", 64'(err_o), 64'(e.err));
      end
    end
  end

  // One transfer; exp_rdata/exp_err are hand-computed by the caller.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input int waits, input logic [31:0] prd, input logic slv,
                      input logic [31:0] exp_rdata, input logic exp_err);
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    req_i = 1'b1; addr_i = a; we_i = w; wdata_i = wd;
    #1 chk("gnt_idle", 64'(gnt_o), 64'd1);
    chk("psel_idle", 64'(psel_o), 64'd0);
    @(negedge clk);
    req_i = 1'b0; addr_i = ~a; wdata_i = ~wd;
    chk("setup_psel_pen", {psel_o, penable_o}, 64'b10);
    chk("setup_gnt", 64'(gnt_o), 64'd0);
    chk("setup_bus", {paddr_o, pwdata_o}, {a, wd});
    chk("setup_pwrite", 64'(pwrite_o), 64'(w));
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("wait_psel_pen", {psel_o, penable_o}, 64'b11);
      chk("wait_bus", {paddr_o, pwdata_o}, {a, wd});
      chk("wait_pwrite", 64'(pwrite_o), 64'(w));
    end
    @(negedge clk);
    chk("access_psel_pen", {psel_o, penable_o}, 64'b11);
    chk("access_bus", {paddr_o, pwdata_o}, {a, wd});
    pready_i = 1'b1; prdata_i = prd; pslverr_i = slv;
    @(negedge clk);
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'hDEAD_BEEF;
    chk("done_rvalid", 64'(rvalid_o), 64'd1);
    chk("done_psel", 64'(psel_o), 64'd0);
    chk("hold_paddr", 64'(paddr_o), 64'(a));
  endtask

  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_data [4];

  initial begin
    b2b_addr = '{32'h1A10_0000, 32'h1A10_2008, 32'h1A11_0010, 32'h1A11_7FFC};
    b2b_data = '{32'h0000_0011, 32'h2222_0022, 32'h3333_0033, 32'h4444_0044};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_psel_pen", {psel_o, penable_o}, 64'b00);
    chk("rst_rvalid_err", {rvalid_o, err_o}, 64'b00);
    chk("rst_bus", {paddr_o, pwdata_o}, 64'd0);
    chk("rst_rdata_pwrite", {rdata_o, pwrite_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_gnt_noreq", 64'(gnt_o), 64'd0);

    // 1: zero-wait read
    xfer(32'h1A10_1000, 1'b0, 32'h0, 0, 32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 1'b0);
    @(negedge clk);
    chk("rvalid_pulse_1cyc", 64'(rvalid_o), 64'd0);
    chk("rdata_holds", 64'(rdata_o), 64'hA5A5_0001);

    // 2: write with 3 wait states, rdata forced to 0
    xfer(32'h1A10_3004, 1'b1, 32'h0000_00FF, 3, 32'h5555_5555, 1'b0, 32'h0, 1'b0);

    // 3: read with pslverr
    xfer(32'h1A10_4000, 1'b0, 32'h0, 0, 32'h0000_1234, 1'b1, 32'h0, 1'b1);

    // 4: timeout after 16 ACCESS cycles, late pready ignored
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    @(negedge clk);
    req_i = 1'b1; addr_i = 32'h1A10_5000; we_i = 1'b0;
    @(negedge clk);
    req_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("to_access", {psel_o, penable_o}, 64'b11);
    end
    @(negedge clk);
    chk("to_psel_drop", 64'(psel_o), 64'd0);
    chk("to_rvalid", 64'(rvalid_o), 64'd1);
    pready_i = 1'b1; prdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    pready_i = 1'b0;
    chk("late_pready_psel", {psel_o, rvalid_o}, 64'b00);
    @(negedge clk);
    chk("late_pready_rvalid", 64'(rvalid_o), 64'd0);

    // 5: req held high for 4 reads, pready held high
    for (int k = 0; k < 4; k++) exp_q.push_back('{rdata: b2b_data[k], err: 1'b0});
    pready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_i = 1'b1; addr_i = b2b_addr[k]; we_i = 1'b0; prdata_i = b2b_data[k];
      #1 chk("b2b_gnt", 64'(gnt_o), 64'd1);
      @(negedge clk);
      chk("b2b_setup_gnt", 64'(gnt_o), 64'd0);
      chk("b2b_paddr", 64'(paddr_o), 64'(b2b_addr[k]));
      @(negedge clk);
      chk("b2b_access", {gnt_o, psel_o, penable_o}, 64'b011);
      if (k == 3) req_i = 1'b0;
    end
    @(negedge clk);
    pready_i = 1'b0;
    chk("b2b_end_psel", 64'(psel_o), 64'd0);

    // 6: async reset during ACCESS drops the transfer silently
    @(negedge clk);
    req_i = 1'b1; addr_i = 32'h1A10_6000; we_i = 1'b0;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_access", {psel_o, penable_o}, 64'b11);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_drop", {psel_o, penable_o}, 64'b00);
    @(negedge clk);
    pready_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    pready_i = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", 64'(rvalid_o), 64'd0);
    xfer(32'h1A10_7000, 1'b0, 32'h0, 1, 32'hC0DE_0006, 1'b0, 32'hC0DE_0006, 1'b0);

    repeat (3) @(negedge clk);
    chk("all_responses_seen", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
